// File: rtl/priority_resolver_pipe.sv
// Two-stage per-pixel layer priority resolver: picks the top (and optionally runner-up) layer.
// Define PRIO_SECOND_TARGET_EN to build the runner-up logic; otherwise out_second is the backdrop.
module priority_resolver_pipe #(
  parameter int NUM_LAYERS = 5,
  parameter int PIXEL_W    = 20,
  parameter int PRIO_W     = 3,
  parameter int LINE_W     = 240,
  localparam int ID_W      = $clog2(NUM_LAYERS + 1),
  localparam int X_W       = $clog2(LINE_W)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_LAYERS*PIXEL_W-1:0] in_pix,
  input  logic [NUM_LAYERS-1:0]         in_opaque,
  input  logic [NUM_LAYERS-1:0]         in_mask,
  input  logic [PIXEL_W-1:0]            in_backdrop,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [PIXEL_W-1:0]            out_first,
  output logic [ID_W-1:0]               out_first_id,
  output logic [PIXEL_W-1:0]            out_second,
  output logic [ID_W-1:0]               out_second_id,
  output logic [X_W-1:0]                out_x,
  output logic                          out_eol,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam logic [ID_W-1:0] BD_ID  = ID_W'(NUM_LAYERS);
  localparam logic [X_W-1:0]  X_LAST = X_W'(LINE_W - 1);

  logic                          s1_valid_q, s1_valid_d;
  logic [NUM_LAYERS*PIXEL_W-1:0] s1_pix_q, s1_pix_d;
  logic [NUM_LAYERS-1:0]         s1_qual_q, s1_qual_d;
  logic [PIXEL_W-1:0]            s1_bd_q, s1_bd_d;

  logic                          out_valid_q, out_valid_d;
  logic [PIXEL_W-1:0]            first_q, first_d, second_q, second_d;
  logic [ID_W-1:0]               first_id_q, first_id_d, second_id_q, second_id_d;
  logic [X_W-1:0]                x_q, x_d;

  logic                          s1_adv, s2_adv;
  logic [PIXEL_W-1:0]            first_c, second_c;
  logic [ID_W-1:0]               first_id_c, second_id_c;

  assign s2_adv   = ~out_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // Strict '<' keeps the earlier (lower-index) layer on a priority tie.
  always_comb begin : resolve_first
    logic               found;
    logic [PRIO_W-1:0]  best;
    logic [PIXEL_W-1:0] word;
    found      = 1'b0;
    best       = '0;
    word       = '0;
    first_c    = s1_bd_q;
    first_id_c = BD_ID;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      word = s1_pix_q[i*PIXEL_W +: PIXEL_W];
      if (s1_qual_q[i] && (!found || word[PIXEL_W-1 -: PRIO_W] < best)) begin
        found      = 1'b1;
        best       = word[PIXEL_W-1 -: PRIO_W];
        first_c    = word;
        first_id_c = ID_W'(i);
      end
    end
  end

`ifdef PRIO_SECOND_TARGET_EN
  always_comb begin : resolve_second
    logic               found;
    logic [PRIO_W-1:0]  best;
    logic [PIXEL_W-1:0] word;
    found       = 1'b0;
    best        = '0;
    word        = '0;
    second_c    = s1_bd_q;
    second_id_c = BD_ID;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      word = s1_pix_q[i*PIXEL_W +: PIXEL_W];
      if (s1_qual_q[i] && (ID_W'(i) != first_id_c) &&
          (!found || word[PIXEL_W-1 -: PRIO_W] < best)) begin
        found       = 1'b1;
        best        = word[PIXEL_W-1 -: PRIO_W];
        second_c    = word;
        second_id_c = ID_W'(i);
      end
    end
  end
`else
  assign second_c    = s1_bd_q;
  assign second_id_c = BD_ID;
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_pix_d    = s1_pix_q;
    s1_qual_d   = s1_qual_q;
    s1_bd_d     = s1_bd_q;
    out_valid_d = out_valid_q;
    first_d     = first_q;
    first_id_d  = first_id_q;
    second_d    = second_q;
    second_id_d = second_id_q;
    x_d         = x_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_pix_d  = in_pix;
        s1_qual_d = in_opaque & in_mask;
        s1_bd_d   = in_backdrop;
      end
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        first_d     = first_c;
        first_id_d  = first_id_c;
        second_d    = second_c;
        second_id_d = second_id_c;
      end
    end
    if (out_valid_q && out_ready) begin
      x_d = (x_q == X_LAST) ? '0 : x_q + X_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_pix_q    <= '0;
      s1_qual_q   <= '0;
      s1_bd_q     <= '0;
      out_valid_q <= 1'b0;
      first_q     <= '0;
      first_id_q  <= BD_ID;
      second_q    <= '0;
      second_id_q <= BD_ID;
      x_q         <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_pix_q    <= s1_pix_d;
      s1_qual_q   <= s1_qual_d;
      s1_bd_q     <= s1_bd_d;
      out_valid_q <= out_valid_d;
      first_q     <= first_d;
      first_id_q  <= first_id_d;
      second_q    <= second_d;
      second_id_q <= second_id_d;
      x_q         <= x_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_first     = first_q;
  assign out_first_id  = first_id_q;
  assign out_second    = second_q;
  assign out_second_id = second_id_q;
  assign out_x         = x_q;
  assign out_eol       = (x_q == X_LAST);

endmodule

// File: tb/tb_priority_resolver_pipe.sv
// Bench for priority_resolver_pipe: random and directed beats checked against a ranking model.
// Expectations follow PRIO_SECOND_TARGET_EN the same way the design build does.
module tb_priority_resolver_pipe;
  localparam int N   = 5;
  localparam int PW  = 20;
  localparam int PRW = 3;
  localparam int LW  = 240;
  localparam int IDW = 3;
  localparam int XW  = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [N*PW-1:0] in_pix;
  logic [N-1:0]    in_opaque, in_mask;
  logic [PW-1:0]   in_backdrop;
  logic            in_valid, in_ready;
  logic [PW-1:0]   out_first, out_second;
  logic [IDW-1:0]  out_first_id, out_second_id;
  logic [XW-1:0]   out_x;
  logic            out_eol, out_valid, out_ready;

  priority_resolver_pipe #(.NUM_LAYERS(N), .PIXEL_W(PW), .PRIO_W(PRW), .LINE_W(LW)) dut (
    .clock(clock), .reset(reset), .in_pix(in_pix), .in_opaque(in_opaque), .in_mask(in_mask),
    .in_backdrop(in_backdrop), .in_valid(in_valid), .in_ready(in_ready),
    .out_first(out_first), .out_first_id(out_first_id), .out_second(out_second),
    .out_second_id(out_second_id), .out_x(out_x), .out_eol(out_eol),
    .out_valid(out_valid), .out_ready(out_ready));

  always #5 clock = ~clock;

  typedef struct {
    logic [PW-1:0] f;
    int            fid;
    logic [PW-1:0] s;
    int            sid;
    int            x;
    bit            eol;
    int            xe;
    int            cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    acc_q[$];
  int    xm, cyc, acc_total;
  int    n_tests, n_fail;

  // Rank qualifying layers by (priority, index); best and second best win.
  function automatic beat_t model(input logic [N*PW-1:0] p, input logic [N-1:0] opq,
                                  input logic [N-1:0] msk, input logic [PW-1:0] bd);
    beat_t b;
    int best = -1, sec = -1, bkey = 0, skey = 0, key;
    logic [PW-1:0] w;
    for (int i = 0; i < N; i++) begin
      if (opq[i] && msk[i]) begin
        w   = p[i*PW +: PW];
        key = int'(w[PW-1 -: PRW]) * N + i;
        if (best < 0 || key < bkey) begin
          sec = best; skey = bkey; best = i; bkey = key;
        end else if (sec < 0 || key < skey) begin
          sec = i; skey = key;
        end
      end
    end
    b.f   = (best < 0) ? bd : p[best*PW +: PW];
    b.fid = (best < 0) ? N : best;
`ifdef PRIO_SECOND_TARGET_EN
    b.s   = (sec < 0) ? bd : p[sec*PW +: PW];
    b.sid = (sec < 0) ? N : sec;
`else
    b.s   = bd;
    b.sid = N;
`endif
    b.x = 0; b.eol = 0; b.xe = 0; b.cyc = 0;
    return b;
  endfunction

  function automatic logic [PW-1:0] mkw(input int prio);
    logic [PW-1:0] w;
    w = PW'($urandom);
    w[PW-1 -: PRW] = PRW'(prio);
    return w;
  endfunction

  task automatic rnd_beat();
    for (int i = 0; i < N; i++) in_pix[i*PW +: PW] = mkw($urandom_range(0, 7));
    in_opaque   = N'($urandom);
    in_mask     = N'($urandom) | N'($urandom);
    in_backdrop = PW'($urandom);
  endtask

  // Called at posedge+1; samples handshakes at the falling edge, returns at next posedge+1.
  task automatic cycle();
    beat_t b;
    #4;
    if (!reset) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_pix, in_opaque, in_mask, in_backdrop));
        acc_q.push_back(cyc);
        acc_total++;
      end
      if (out_valid && out_ready) begin
        b.f = out_first; b.fid = int'(out_first_id);
        b.s = out_second; b.sid = int'(out_second_id);
        b.x = int'(out_x); b.eol = out_eol; b.xe = xm; b.cyc = cyc;
        obs_q.push_back(b);
        xm = (xm + 1) % LW;
      end
    end
    @(posedge clock);
    cyc++;
    if (reset) begin
      exp_q.delete(); obs_q.delete(); acc_q.delete(); xm = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; rnd_beat();
    cycle(); cycle();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_tests++; if (out_x !== '0) begin n_fail++; $display("FAIL reset_out_x got=%0d want=0", out_x); end
    n_tests++; if (out_first !== '0) begin n_fail++; $display("FAIL reset_first got=%h want=0", out_first); end
    n_tests++; if (out_second !== '0) begin n_fail++; $display("FAIL reset_second got=%h want=0", out_second); end
    n_tests++; if (int'(out_first_id) !== N) begin n_fail++; $display("FAIL reset_first_id got=%0d want=%0d", out_first_id, N); end
    n_tests++; if (int'(out_second_id) !== N) begin n_fail++; $display("FAIL reset_second_id got=%0d want=%0d", out_second_id, N); end
    reset = 1'b0; in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_directed();
    logic [PW-1:0] w[N];
    int prios[N] = '{3, 1, 2, 1, 0};
    beat_t o;
    // Vector 1: all qualify, tie between layers 1 and 3
    for (int i = 0; i < N; i++) begin w[i] = mkw(prios[i]); in_pix[i*PW +: PW] = w[i]; end
    in_opaque = '1; in_mask = '1; in_backdrop = 20'h12345; in_valid = 1'b1; out_ready = 1'b1;
    obs_q.delete(); exp_q.delete();
    cycle(); in_valid = 1'b0; repeat (3) cycle();
    n_tests++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL dir1_count got=%0d want=1", obs_q.size()); end
    else begin
      o = obs_q.pop_front();
      n_tests++; if (o.fid !== 4) begin n_fail++; $display("FAIL dir1_first_id got=%0d want=4", o.fid); end
      n_tests++; if (o.f !== w[4]) begin n_fail++; $display("FAIL dir1_first got=%h want=%h", o.f, w[4]); end
`ifdef PRIO_SECOND_TARGET_EN
      n_tests++; if (o.sid !== 1) begin n_fail++; $display("FAIL dir1_second_id got=%0d want=1", o.sid); end
      n_tests++; if (o.s !== w[1]) begin n_fail++; $display("FAIL dir1_second got=%h want=%h", o.s, w[1]); end
`else
      n_tests++; if (o.sid !== N) begin n_fail++; $display("FAIL dir1_second_id got=%0d want=%0d", o.sid, N); end
      n_tests++; if (o.s !== 20'h12345) begin n_fail++; $display("FAIL dir1_second got=%h want=12345", o.s); end
`endif
    end
    // Vector 2: nothing masked in, backdrop on both targets
    in_mask = '0; in_backdrop = 20'h0ABCD; in_valid = 1'b1;
    cycle(); in_valid = 1'b0; repeat (3) cycle();
    n_tests++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL dir2_count got=%0d want=1", obs_q.size()); end
    else begin
      o = obs_q.pop_front();
      n_tests++; if (o.f !== 20'h0ABCD || o.fid !== N) begin n_fail++; $display("FAIL dir2_first got=%h/%0d want=0abcd/%0d", o.f, o.fid, N); end
      n_tests++; if (o.s !== 20'h0ABCD || o.sid !== N) begin n_fail++; $display("FAIL dir2_second got=%h/%0d want=0abcd/%0d", o.s, o.sid, N); end
    end
    // Vector 3: only layer 2 both opaque and masked
    in_opaque = 5'b10110; in_mask = 5'b00101; in_backdrop = 20'h55AA5; in_valid = 1'b1;
    cycle(); in_valid = 1'b0; repeat (3) cycle();
    n_tests++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL dir3_count got=%0d want=1", obs_q.size()); end
    else begin
      o = obs_q.pop_front();
      n_tests++; if (o.f !== w[2] || o.fid !== 2) begin n_fail++; $display("FAIL dir3_first got=%h/%0d want=%h/2", o.f, o.fid, w[2]); end
      n_tests++; if (o.s !== 20'h55AA5 || o.sid !== N) begin n_fail++; $display("FAIL dir3_second got=%h/%0d want=55aa5/%0d", o.s, o.sid, N); end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    beat_t o, e;
    for (int c = 0; c < 400; c++) begin
      rnd_beat();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_extra_beat x=%0d", o.x); end
      else begin
        e = exp_q.pop_front();
        if (o.f !== e.f || o.fid !== e.fid || o.s !== e.s || o.sid !== e.sid ||
            o.x !== o.xe || o.eol !== (o.xe == LW - 1)) begin
          n_fail++;
          $display("FAIL rand_beat got=%h/%0d %h/%0d x%0d eol%0d want=%h/%0d %h/%0d x%0d",
                   o.f, o.fid, o.s, o.sid, o.x, o.eol, e.f, e.fid, e.s, e.sid, o.xe);
        end
      end
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_stream();
    beat_t o, e;
    int first_acc;
    reset = 1'b1; cycle(); reset = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < LW + 1; c++) begin rnd_beat(); cycle(); end
    in_valid = 1'b0;
    repeat (4) cycle();
    first_acc = (acc_q.size() > 0) ? acc_q[0] : -100;
    n_tests++; if (obs_q.size() != LW + 1) begin n_fail++; $display("FAIL stream_count got=%0d want=%0d", obs_q.size(), LW + 1); end
    n_tests++; if (obs_q.size() > 0 && obs_q[0].cyc - first_acc !== 2) begin
      n_fail++; $display("FAIL stream_latency got=%0d want=2", obs_q[0].cyc - first_acc); end
    for (int k = 0; k < LW + 1 && obs_q.size() > 0; k++) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : o;
      n_tests++;
      if (o.x !== k % LW || o.eol !== (k == LW - 1) || o.cyc !== first_acc + 2 + k ||
          o.f !== e.f || o.fid !== e.fid || o.s !== e.s || o.sid !== e.sid) begin
        n_fail++;
        $display("FAIL stream_beat k=%0d got x%0d eol%0d cyc%0d %h/%0d want x%0d eol%0d cyc%0d %h/%0d",
                 k, o.x, o.eol, o.cyc, o.f, o.fid, k % LW, (k == LW - 1), first_acc + 2 + k, e.f, e.fid);
      end
    end
  endtask

  task automatic test_stall();
    beat_t o, e;
    logic [PW-1:0] sf, ss;
    logic [IDW-1:0] sfi, ssi;
    logic [XW-1:0] sx;
    int acc0;
    obs_q.delete(); exp_q.delete();
    acc0 = acc_total;
    in_valid = 1'b1; out_ready = 1'b0;
    rnd_beat(); cycle(); rnd_beat(); cycle();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got=%b want=1", out_valid); end
    sf = out_first; ss = out_second; sfi = out_first_id; ssi = out_second_id; sx = out_x;
    for (int c = 0; c < 3; c++) begin
      rnd_beat(); cycle();
      n_tests++;
      if (out_valid !== 1'b1 || out_first !== sf || out_second !== ss || out_first_id !== sfi ||
          out_second_id !== ssi || out_x !== sx) begin
        n_fail++; $display("FAIL stall_hold c=%0d got=%h/%0d x%0d want=%h/%0d x%0d", c, out_first, out_first_id, out_x, sf, sfi, sx);
      end
    end
    n_tests++; if (acc_total - acc0 !== 2) begin n_fail++; $display("FAIL stall_accepts got=%0d want=2", acc_total - acc0); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin rnd_beat(); cycle(); end
    in_valid = 1'b0;
    repeat (4) cycle();
    n_tests++; if (obs_q.size() != acc_total - acc0) begin n_fail++; $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), acc_total - acc0); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o.f !== e.f || o.fid !== e.fid || o.s !== e.s || o.sid !== e.sid || o.x !== o.xe) begin
        n_fail++; $display("FAIL stall_order got=%h/%0d x%0d want=%h/%0d x%0d", o.f, o.fid, o.x, e.f, e.fid, o.xe);
      end
    end
  endtask

  task automatic test_reset_midstream();
    beat_t o, e;
    in_valid = 1'b1; out_ready = 1'b1;
    rnd_beat(); cycle(); rnd_beat(); cycle();
    in_valid = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
    rnd_beat(); in_valid = 1'b1; cycle(); in_valid = 1'b0;
    repeat (4) cycle();
    n_tests++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL rst_mid_count got=%0d want=1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++; if (o.x !== 0) begin n_fail++; $display("FAIL rst_mid_x got=%0d want=0", o.x); end
      n_tests++; if (o.f !== e.f || o.fid !== e.fid || o.s !== e.s || o.sid !== e.sid) begin
        n_fail++; $display("FAIL rst_mid_data got=%h/%0d want=%h/%0d", o.f, o.fid, e.f, e.fid); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; xm = 0; cyc = 0; acc_total = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_pix = '0; in_opaque = '0; in_mask = '0; in_backdrop = '0;
    @(posedge clock); #1;
    test_reset();
    test_directed();
    test_random();
    test_stream();
    test_stall();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/priority_resolver_pipe.md
PRIORITY_RESOLVER_PIPE -- requirements
Module: priority_resolver_pipe

Interface
REQ-001 Parameter NUM_LAYERS, default 5, is the number of candidate layers per pixel (2..8).
REQ-002 Parameter PIXEL_W, default 20, is the width of each layer pixel word.
REQ-003 Parameter PRIO_W, default 3, is the width of the priority field at bits [PIXEL_W-1 -: PRIO_W]; a lower value means higher priority.
REQ-004 Parameter LINE_W, default 240, is the number of pixels per scanline.
REQ-005 Port list (clock and reset first):
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_pix  in  NUM_LAYERS*PIXEL_W  layer pixel words; layer i occupies [i*PIXEL_W +: PIXEL_W].
- in_opaque  in  NUM_LAYERS  per-layer non-transparent flag.
- in_mask  in  NUM_LAYERS  per-layer window/enable mask.
- in_backdrop  in  PIXEL_W  backdrop word used when no layer qualifies.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
- out_first  out  PIXEL_W  winning (top) pixel word.
- out_first_id  out  ID_W  winning layer index; NUM_LAYERS means backdrop.
- out_second  out  PIXEL_W  runner-up pixel word (blend second target).
- out_second_id  out  ID_W  runner-up layer index; NUM_LAYERS means backdrop.
- out_x  out  $clog2(LINE_W)  pixel position of the current output beat.
- out_eol  out  1  high on the output beat where out_x == LINE_W-1.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
REQ-006 ID_W SHALL equal $clog2(NUM_LAYERS+1).

Function
REQ-007 Layer i SHALL qualify when in_opaque[i] and in_mask[i] are both 1.
REQ-008 The first target SHALL be the qualifying layer with the numerically lowest priority field; equal priority SHALL resolve to the lower layer index.
REQ-009 The second target SHALL be the best qualifying layer other than the first target, using the same ordering.
REQ-010 With zero qualifying layers, both targets SHALL be in_backdrop with ID NUM_LAYERS; with exactly one, the second target SHALL be the backdrop.
REQ-011 The pipeline SHALL have two register stages (S1 captures qualified inputs, S2 holds results), so an accepted beat reaches out_valid exactly 2 cycles later when there is no stall.
REQ-012 S2 SHALL advance when ~out_valid | out_ready; S1 SHALL advance when ~s1_valid | S2 advances; in_ready SHALL equal that S1 advance condition.
REQ-013 The block SHALL sustain one beat per cycle with out_ready held high, with no bubbles.
REQ-014 While out_valid & ~out_ready, all out_* signals SHALL hold stable and no beat SHALL be dropped or duplicated.
REQ-015 out_x SHALL increment on each output handshake and wrap from LINE_W-1 to 0; out_eol SHALL be combinational from out_x.
REQ-016 Input data SHALL be ignored when in_valid is low.

Reset
REQ-017 While reset is high: s1_valid=0, out_valid=0, out_x=0, out_first=out_second=0, out_first_id=out_second_id=NUM_LAYERS; in_ready=1.
REQ-018 Reset asserted mid-stream SHALL discard all in-flight beats; the first beat accepted after reset SHALL report out_x=0.

Configuration
REQ-019 Macro PRIO_SECOND_TARGET_EN: when defined, second-target logic SHALL operate per REQ-009/010.
REQ-020 When PRIO_SECOND_TARGET_EN is undefined, out_second SHALL equal the registered backdrop and out_second_id SHALL equal NUM_LAYERS for every beat, and no runner-up logic SHALL be synthesised; all other behaviour SHALL be unchanged.

Verification
REQ-021 Priorities {3,1,2,1,0}, all qualify -> first_id=4, second_id=1 (tie 1 vs 3 resolves to lower index).
REQ-022 All in_mask=0, backdrop=0x0ABCD -> first=second=0x0ABCD, both IDs=5.
REQ-023 Only layer 2 opaque and masked -> first_id=2, second_id=5; with the macro undefined -> second_id=5 for every REQ-021 stimulus.
REQ-024 Stream 240 beats with out_ready=1 -> valid 2 cycles after the first accept, no gaps, out_eol only on beat 239, next beat out_x=0.
REQ-025 Hold out_ready=0 for 5 cycles mid-stream -> in_ready drops after 2 further accepts, outputs stay stable, in-order output with no loss after release.
REQ-026 Assert reset for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle, prior beats never appear, and the next beat reports out_x=0.
